// File: rtl/commit_trace_fifo_pkg.sv
// Shared types for the commit trace path: one captured retirement record.
package trace_pkg;

  localparam int TRACE_W = 224;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] pre_pc;
    logic [63:0] seq;
  } trace_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/commit_trace_fifo_if.sv
// Commit bundle in, trace stream and status out.
interface commit_trace_fifo_if;
  logic        commit;
  logic [31:0] commit_instr;
  logic [63:0] commit_pc;
  logic [63:0] commit_pre_pc;
  logic        trace_flush;
  logic        trace_ready;
  logic        trace_valid;
  logic [31:0] trace_instr;
  logic [63:0] trace_pc;
  logic [63:0] trace_pre_pc;
  logic [63:0] trace_seq;
  logic        trace_afull;
  logic        trace_full;
  logic [31:0] drop_cnt;
  logic [63:0] instret;

  modport master (
    output commit, commit_instr, commit_pc, commit_pre_pc, trace_flush, trace_ready,
    input  trace_valid, trace_instr, trace_pc, trace_pre_pc, trace_seq,
           trace_afull, trace_full, drop_cnt, instret
  );

  modport slave (
    input  commit, commit_instr, commit_pc, commit_pre_pc, trace_flush, trace_ready,
    output trace_valid, trace_instr, trace_pc, trace_pre_pc, trace_seq,
           trace_afull, trace_full, drop_cnt, instret
  );
endinterface

// File: rtl/commit_trace_fifo_sync_fifo.sv
// Generic single-clock FIFO with flush; head is read combinationally at rd_ptr.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             pop_en, push_en;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // Flush wins over pop; a push while full is legal only when a slot frees this cycle.
  assign pop_en  = pop & ~empty & ~flush;
  assign push_en = push & (~full | pop_en | flush);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= CW'(push_en);
      end else begin
        if (pop_en) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push_en) - CW'(pop_en);
      end
    end
  end
endmodule

// File: rtl/commit_trace_fifo.sv
// Captures retired instructions into a FIFO for a trace sink; counts retirements and drops.
module commit_trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input logic                clk,
  input logic                rst,
  commit_trace_fifo_if.slave tif
);
  localparam int CW = $clog2(DEPTH) + 1;

  trace_entry_t  wr_entry, head;
  logic [CW-1:0] count, occ_nxt;
  logic          fifo_full, fifo_empty;
  logic          pop, accept, drop;
  logic          afull_q, full_q;
  logic [63:0]   instret_q;
  logic [31:0]   drop_q;

  assign pop    = ~fifo_empty & tif.trace_ready;
  // A flush empties the FIFO, so a commit in that cycle always fits.
  assign accept = tif.commit & (~fifo_full | pop | tif.trace_flush);
  assign drop   = tif.commit & ~accept;

  assign wr_entry = '{instr:  tif.commit_instr,
                      pc:     tif.commit_pc,
                      pre_pc: tif.commit_pre_pc,
                      seq:    instret_q};

  always_comb begin
    occ_nxt = count;
    if (tif.trace_flush) occ_nxt = CW'(accept);
    else                 occ_nxt = count + CW'(accept) - CW'(pop);
  end

  sync_fifo #(.WIDTH(TRACE_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .flush (tif.trace_flush),
    .wdata (wr_entry),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      afull_q   <= 1'b0;
      full_q    <= 1'b0;
      instret_q <= '0;
      drop_q    <= '0;
    end else begin
      afull_q   <= (occ_nxt >= CW'(AFULL_LVL));
      full_q    <= (occ_nxt == CW'(DEPTH));
      instret_q <= instret_q + 64'(tif.commit);
      if (drop) drop_q <= sat_inc32(drop_q);
    end
  end

  assign tif.trace_valid  = ~fifo_empty;
  assign tif.trace_instr  = head.instr;
  assign tif.trace_pc     = head.pc;
  assign tif.trace_pre_pc = head.pre_pc;
  assign tif.trace_seq    = head.seq;
  assign tif.trace_afull  = afull_q;
  assign tif.trace_full   = full_q;
  assign tif.drop_cnt     = drop_q;
  assign tif.instret      = instret_q;
endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: queue-based reference model plus directed literal checks.
module tb_commit_trace_fifo;
  import trace_pkg::*;

  localparam int DEPTH     = 8;
  localparam int AFULL_LVL = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;

  commit_trace_fifo_if tif();

  commit_trace_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
    .clk (clk),
    .rst (rst),
    .tif (tif)
  );

  always #5 clk = ~clk;

  // Reference model: an ideal bounded queue of retirement records.
  trace_entry_t mq[$];
  trace_entry_t m_e;
  logic [63:0]  m_instret = '0;
  logic [31:0]  m_drop    = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_instret = '0;
      m_drop    = '0;
    end else begin
      if (tif.trace_flush) mq.delete();
      else if (mq.size() > 0 && tif.trace_ready) void'(mq.pop_front());
      if (tif.commit) begin
        if (mq.size() < DEPTH) begin
          m_e.instr  = tif.commit_instr;
          m_e.pc     = tif.commit_pc;
          m_e.pre_pc = tif.commit_pre_pc;
          m_e.seq    = m_instret;
          mq.push_back(m_e);
        end else if (m_drop != 32'hFFFF_FFFF) begin
          m_drop = m_drop + 32'd1;
        end
        m_instret = m_instret + 64'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_valid", 64'(tif.trace_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("m_seq",    tif.trace_seq,         mq[0].seq);
        chk("m_pc",     tif.trace_pc,          mq[0].pc);
        chk("m_pre_pc", tif.trace_pre_pc,      mq[0].pre_pc);
        chk("m_instr",  64'(tif.trace_instr),  64'(mq[0].instr));
      end
      chk("m_instret", tif.instret,           m_instret);
      chk("m_drop",    64'(tif.drop_cnt),     64'(m_drop));
      chk("m_afull",   64'(tif.trace_afull),  64'(mq.size() >= AFULL_LVL));
      chk("m_full",    64'(tif.trace_full),   64'(mq.size() == DEPTH));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input logic [63:0] pc);
    tif.commit        = c;
    tif.commit_pc     = pc;
    tif.commit_pre_pc = pc + 64'd4;
    tif.commit_instr  = pc[31:0] ^ 32'h0000_0013;
  endtask

  task automatic do_reset();
    drive(1'b0, 64'd0);
    tif.trace_flush = 1'b0;
    tif.trace_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] last_seq;
    logic [63:0] npop;
    bit          first;

    drive(1'b0, 64'd0);
    tif.trace_flush = 1'b0;
    tif.trace_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid",   64'(tif.trace_valid), 64'd0);
    chk("rst_pc",      tif.trace_pc,         64'd0);
    chk("rst_seq",     tif.trace_seq,        64'd0);
    chk("rst_instr",   64'(tif.trace_instr), 64'd0);
    chk("rst_afull",   64'(tif.trace_afull), 64'd0);
    chk("rst_full",    64'(tif.trace_full),  64'd0);
    chk("rst_drop",    64'(tif.drop_cnt),    64'd0);
    chk("rst_instret", tif.instret,          64'd0);
    cmp_en = 1'b1;

    // 1: three commits streaming through with ready high
    tif.trace_ready = 1'b1;
    drive(1'b1, 64'h8000_0000); tick();
    chk("t1_valid0", 64'(tif.trace_valid), 64'd1);
    chk("t1_seq0",   tif.trace_seq, 64'd0);
    chk("t1_pc0",    tif.trace_pc,  64'h8000_0000);
    drive(1'b1, 64'h8000_0004); tick();
    chk("t1_seq1",   tif.trace_seq, 64'd1);
    chk("t1_pc1",    tif.trace_pc,  64'h8000_0004);
    drive(1'b1, 64'h8000_0008); tick();
    chk("t1_seq2",   tif.trace_seq, 64'd2);
    chk("t1_pre2",   tif.trace_pre_pc, 64'h8000_000C);
    drive(1'b0, 64'd0); tick();
    chk("t1_empty",   64'(tif.trace_valid), 64'd0);
    chk("t1_instret", tif.instret, 64'd3);
    chk("t1_drop",    64'(tif.drop_cnt), 64'd0);

    // 2: fill with ready low, overflow by two, then drain in order
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 64'h9000_0000 + 64'(4 * i));
      tick();
      chk("t2_afull", 64'(tif.trace_afull), 64'(i >= 6));
      chk("t2_full",  64'(tif.trace_full),  64'(i >= 8));
    end
    drive(1'b0, 64'd0);
    chk("t2_drop",    64'(tif.drop_cnt), 64'd2);
    chk("t2_instret", tif.instret, 64'd10);
    tif.trace_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t2_drain_seq", tif.trace_seq, 64'(k));
      tick();
    end
    chk("t2_drained", 64'(tif.trace_valid), 64'd0);

    // 3: full, commit and pop together -> accepted, occupancy stays 8
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'hA000_0000 + 64'(4 * i));
      tick();
    end
    chk("t3_full_pre", 64'(tif.trace_full), 64'd1);
    drive(1'b1, 64'hA000_1000);
    tif.trace_ready = 1'b1;
    tick();
    drive(1'b0, 64'd0);
    tif.trace_ready = 1'b0;
    chk("t3_full",    64'(tif.trace_full), 64'd1);
    chk("t3_drop",    64'(tif.drop_cnt), 64'd0);
    chk("t3_instret", tif.instret, 64'd9);
    chk("t3_head",    tif.trace_seq, 64'd1);
    tif.trace_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("t3_drain_seq", tif.trace_seq, 64'(k));
      if (k == 8) chk("t3_last_pc", tif.trace_pc, 64'hA000_1000);
      tick();
    end
    tif.trace_ready = 1'b0;

    // 4: flush with a simultaneous commit leaves exactly that commit
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'hB000_0000 + 64'(4 * i));
      tick();
    end
    drive(1'b1, 64'h1234);
    tif.trace_flush = 1'b1;
    tif.trace_ready = 1'b1;
    tick();
    tif.trace_flush = 1'b0;
    tif.trace_ready = 1'b0;
    drive(1'b0, 64'd0);
    chk("t4_valid",   64'(tif.trace_valid), 64'd1);
    chk("t4_pc",      tif.trace_pc, 64'h1234);
    chk("t4_seq",     tif.trace_seq, 64'd5);
    chk("t4_instret", tif.instret, 64'd6);
    chk("t4_afull",   64'(tif.trace_afull), 64'd0);
    tif.trace_ready = 1'b1;
    tick();
    chk("t4_one_entry", 64'(tif.trace_valid), 64'd0);
    tif.trace_ready = 1'b0;

    // 5a: head holds while stalled
    do_reset();
    drive(1'b1, 64'hB100_0000); tick();
    drive(1'b1, 64'hB100_0004); tick();
    drive(1'b0, 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_hold_pc",  tif.trace_pc, 64'hB100_0000);
      chk("t5_hold_seq", tif.trace_seq, 64'd0);
    end

    // 5b: random ready over 1000 back-to-back commits
    do_reset();
    npop = '0; first = 1'b1; last_seq = '0;
    for (int n = 0; n < 1000; n++) begin
      drive(1'b1, 64'hC000_0000 + 64'(4 * n));
      tif.trace_ready = ($urandom_range(0, 2) == 0);
      if (tif.trace_valid && tif.trace_ready) begin
        if (!first) chk("t5_seq_incr", 64'(tif.trace_seq > last_seq), 64'd1);
        first = 1'b0; last_seq = tif.trace_seq; npop = npop + 64'd1;
      end
      tick();
    end
    drive(1'b0, 64'd0);
    for (int k = 0; k < DEPTH + 2; k++) begin
      tif.trace_ready = 1'b1;
      if (tif.trace_valid) begin
        if (!first) chk("t5_seq_incr", 64'(tif.trace_seq > last_seq), 64'd1);
        first = 1'b0; last_seq = tif.trace_seq; npop = npop + 64'd1;
      end
      tick();
    end
    tif.trace_ready = 1'b0;
    chk("t5_drained",   64'(tif.trace_valid), 64'd0);
    chk("t5_instret",   tif.instret, 64'd1000);
    chk("t5_pops_drops", npop + 64'(tif.drop_cnt), tif.instret);

    // 6: asynchronous reset mid-burst
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 64'hD000_0000 + 64'(4 * i));
      tick();
    end
    drive(1'b0, 64'd0);
    chk("t6_afull_pre", 64'(tif.trace_afull), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid",   64'(tif.trace_valid), 64'd0);
    chk("t6_instret", tif.instret, 64'd0);
    chk("t6_drop",    64'(tif.drop_cnt), 64'd0);
    chk("t6_afull",   64'(tif.trace_afull), 64'd0);
    chk("t6_full",    64'(tif.trace_full), 64'd0);
    chk("t6_pc",      tif.trace_pc, 64'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 64'hD100_0000); tick();
    drive(1'b0, 64'd0);
    chk("t6_after_valid", 64'(tif.trace_valid), 64'd1);
    chk("t6_after_seq",   tif.trace_seq, 64'd0);
    tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
